universal_shift_register: RTL

Parametrised successor to the family's fixed-width cyclic shifters. It holds a WIDTH-bit register that can be loaded, cleared, rotated or shifted in either direction by a run-time amount. Rotates and logical/arithmetic shifts run under a start/busy/done handshake, iteratively at one bit per clock. It sits as a datapath element under a controller FSM in the experiment top-levels.

---
 rtl/usr_pkg.sv | 27 ++
 rtl/universal_shift_register_if.sv | 30 +++
 rtl/usr_shift_step.sv | 61 ++++++
 rtl/universal_shift_register.sv | 130 +++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: command and FSM encodings, amount-width helper.
// No logic of its own; imported by the interface, the step datapath and the top.
// No flow control here.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_LOAD  = 3'd0,
    MODE_ROR   = 3'd1,
    MODE_ROL   = 3'd2,
    MODE_SRL   = 3'd3,
    MODE_SLL   = 3'd4,
    MODE_SRA   = 3'd5,
    MODE_CLEAR = 3'd6,
    MODE_NOP   = 3'd7
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Width of the shift-amount field for a given register width.
  function automatic int usr_amt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Command/result bundle between a controller (master) and the shift register (slave).
// Purely wiring, no latency.
// No backpressure: commands are strobes, and the slave drops any command issued while busy.
interface universal_shift_register_if
  import usr_pkg::*;
#(
  parameter int WIDTH = 128
);
  localparam int AMT_W = usr_amt_w(WIDTH);

  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] load_data;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amount, load_data, serial_in,
    input  q, busy, done
  );

  modport slave (
    input  start, mode, amount, load_data, serial_in,
    output q, busy, done
  );

endinterface

// File: rtl/usr_shift_step.sv
// Combinational next-value for q: a single-bit step, or a full barrel shift when USR_BARREL_EN is defined.
// Zero latency (pure combinational).
// No flow control; the caller decides when the result is registered.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int  WIDTH = 128,
  localparam int AMT_W = usr_amt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] q_i,
  input  mode_e            mode_i,
  input  logic             fill_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [WIDTH-1:0] q_o
);

`ifdef USR_BARREL_EN
  // Rotates wrap modulo WIDTH; shifts run on a 2*WIDTH field so amounts >= WIDTH saturate to all-fill.
  logic                 sfill;
  logic [AMT_W-1:0]     rot_amt;
  logic [2*WIDTH-1:0]   dbl;
  logic [2*WIDTH-1:0]   rfill;
  logic [2*WIDTH-1:0]   lfill;

  assign sfill   = (mode_i == MODE_SRA) ? q_i[WIDTH-1] : fill_i;
  assign rot_amt = AMT_W'(int'(amt_i) % WIDTH);
  assign dbl     = {q_i, q_i};
  assign rfill   = {{WIDTH{sfill}}, q_i};
  assign lfill   = {q_i, {WIDTH{sfill}}};

  // Select the barrel result for the requested shift kind.
  always_comb begin
    q_o = q_i;
    case (mode_i)
      MODE_ROR:           q_o = WIDTH'(dbl >> rot_amt);
      MODE_ROL:           q_o = WIDTH'((dbl << rot_amt) >> WIDTH);
      MODE_SRL, MODE_SRA: q_o = WIDTH'(rfill >> amt_i);
      MODE_SLL:           q_o = WIDTH'((lfill << amt_i) >> WIDTH);
      default:            q_o = q_i;
    endcase
  end
`else
  // The iterative build walks the distance in the top-level counter, so the amount is not needed here.
  logic unused_amt;
  assign unused_amt = ^amt_i;

  // One-bit move in the requested direction; SRA replicates the sign bit.
  always_comb begin
    q_o = q_i;
    case (mode_i)
      MODE_ROR: q_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ROL: q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_SRL: q_o = {fill_i, q_i[WIDTH-1:1]};
      MODE_SLL: q_o = {q_i[WIDTH-2:0], fill_i};
      MODE_SRA: q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      default:  q_o = q_i;
    endcase
  end
`endif

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit load/clear/rotate/shift register; state updates on the falling clock edge. Option macro: USR_BARREL_EN.
// Latency: LOAD/CLEAR/NOP/amount-0 in 1 edge; shifts take amount+1 edges (1 edge when USR_BARREL_EN is defined).
// Backpressure: busy is high during an iterative shift; start is ignored (command dropped) until done.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic                        clock,
  input  logic                        reset,
  universal_shift_register_if.slave   bus
);

  mode_e            cmd_mode;
  logic             is_shift;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] step_q;
  logic             done_q, done_d;

  assign cmd_mode = mode_e'(bus.mode);
  assign is_shift = (cmd_mode == MODE_ROR) || (cmd_mode == MODE_ROL) ||
                    (cmd_mode == MODE_SRL) || (cmd_mode == MODE_SLL) ||
                    (cmd_mode == MODE_SRA);

`ifdef USR_BARREL_EN
  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q_i   (q_q),
    .mode_i(cmd_mode),
    .fill_i(bus.serial_in),
    .amt_i (bus.amount),
    .q_o   (step_q)
  );

  // Every command finishes on the edge it is accepted; a zero amount leaves q unchanged through the barrel.
  always_comb begin
    q_d    = q_q;
    done_d = 1'b0;
    if (bus.start) begin
      done_d = 1'b1;
      if (cmd_mode == MODE_LOAD)       q_d = bus.load_data;
      else if (cmd_mode == MODE_CLEAR) q_d = '0;
      else if (is_shift)               q_d = step_q;
    end
  end

  assign bus.busy = 1'b0;
`else
  localparam int AMT_W = usr_amt_w(WIDTH);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             fill_q, fill_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q_i   (q_q),
    .mode_i(mode_q),
    .fill_i(fill_q),
    .amt_i (cnt_q),
    .q_o   (step_q)
  );

  // IDLE accepts commands; SHIFT applies one bit per edge and ignores the command inputs.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_shift && (bus.amount != '0)) begin
            state_d = ST_SHIFT;
            mode_d  = cmd_mode;
            fill_d  = bus.serial_in;
            cnt_d   = bus.amount;
          end else begin
            done_d = 1'b1;
            if (cmd_mode == MODE_LOAD)       q_d = bus.load_data;
            else if (cmd_mode == MODE_CLEAR) q_d = '0;
          end
        end
      end
      ST_SHIFT: begin
        q_d   = step_q;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, latched command and remaining-step counter.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LOAD;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == ST_SHIFT);
`endif

  // Register contents and the registered completion pulse.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.done = done_q;

endmodule
